// File: rtl/mod_reduce_seq.sv
// Bit-serial restoring modular reducer: r = x mod p, one product bit per cycle.
// Sits behind the Booth multiplier wrapper and shares its start/done handshake.
module mod_reduce_seq #(
    parameter int unsigned width = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*width-1:0]   x,
    input  logic [width-1:0]     p,
    input  logic                 start,
    output logic [width-1:0]     r,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned XW = 2 * width;
    localparam int unsigned CW = $clog2(XW);
    localparam logic [CW-1:0] LAST = CW'(XW - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state, state_n;
    logic [XW-1:0]    x_sr, x_sr_n;
    logic [width-1:0] p_q, p_q_n;
    logic [width-1:0] acc, acc_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [width-1:0] r_n;
    logic             done_n, busy_n, err_n;

    // One restoring step: t = 2*acc + next bit < 2p, so width+1 bits never overflow.
    logic [width:0]   t;
    logic [width-1:0] acc_step;
    always_comb begin
        t        = {acc, x_sr[XW-1]};
        acc_step = t[width-1:0];
        if (t >= {1'b0, p_q}) begin
            acc_step = width'(t - {1'b0, p_q});
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        x_sr_n  = x_sr;
        p_q_n   = p_q;
        acc_n   = acc;
        cnt_n   = cnt;
        r_n     = r;
        done_n  = done;
        busy_n  = busy;
        err_n   = err;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    x_sr_n = x;
                    p_q_n  = p;
                    acc_n  = '0;
                    cnt_n  = '0;
                    done_n = 1'b0;
                    err_n  = 1'b0;
                    if (p == '0) begin
                        // Zero modulus: report immediately instead of running.
                        state_n = DONE;
                        r_n     = '0;
                        err_n   = 1'b1;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_n  = acc_step;
                x_sr_n = {x_sr[XW-2:0], 1'b0};
                cnt_n  = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_n = DONE;
                    r_n     = acc_step;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x_sr  <= '0;
            p_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            r     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            x_sr  <= x_sr_n;
            p_q   <= p_q_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            r     <= r_n;
            done  <= done_n;
            busy  <= busy_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed + random bench for mod_reduce_seq at width 8 and width 128.
module tb_mod_reduce_seq;

    typedef struct {
        logic [127:0] r;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // width = 8 instance
    logic        reset8, st8;
    logic [15:0] x8;
    logic [7:0]  p8, r8;
    logic        done8, busy8, err8;

    // width = 128 instance
    logic         reset128, st128;
    logic [255:0] x128;
    logic [127:0] p128, r128;
    logic         done128, busy128, err128;

    mod_reduce_seq #(.width(8)) dut8 (
        .clk(clk), .reset(reset8), .x(x8), .p(p8), .start(st8),
        .r(r8), .done(done8), .busy(busy8), .err(err8)
    );

    mod_reduce_seq #(.width(128)) dut128 (
        .clk(clk), .reset(reset128), .x(x128), .p(p128), .start(st128),
        .r(r128), .done(done128), .busy(busy128), .err(err128)
    );

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t q8[$];
    exp_t q128[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one start on the 8-bit DUT and queue the golden result.
    task automatic go8(input logic [15:0] xv, input logic [7:0] pv);
        exp_t e;
        x8 = xv; p8 = pv; st8 = 1'b1;
        tick;
        st8 = 1'b0;
        e.err = (pv == 8'd0);
        e.r   = (pv == 8'd0) ? 128'd0 : 128'(xv % {8'd0, pv});
        q8.push_back(e);
    endtask

    // Wait (bounded) for done, then compare latency and the queued result.
    task automatic wait8(input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        chk("lat8", 256'(n), 256'(exp_lat));
        e = q8.pop_front();
        chk("r8", 256'(r8), 256'(e.r[7:0]));
        chk("err8", 256'(err8), 256'(e.err));
        chk("busy8_done", 256'(busy8), 256'd0);
    endtask

    task automatic go128(input logic [255:0] xv, input logic [127:0] pv);
        exp_t e;
        x128 = xv; p128 = pv; st128 = 1'b1;
        tick;
        st128 = 1'b0;
        e.err = (pv == 128'd0);
        e.r   = (pv == 128'd0) ? 128'd0 : 128'(xv % {128'd0, pv});
        q128.push_back(e);
    endtask

    task automatic wait128(input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        while (done128 !== 1'b1 && n < 400) begin
            tick;
            n++;
        end
        chk("lat128", 256'(n), 256'(exp_lat));
        e = q128.pop_front();
        chk("r128", 256'(r128), 256'(e.r));
        chk("err128", 256'(err128), 256'(e.err));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] pv, pm1;
        logic [255:0] xv;

        reset8 = 1'b1; reset128 = 1'b1;
        st8 = 1'b0; st128 = 1'b0;
        x8 = '0; p8 = '0; x128 = '0; p128 = '0;
        tick; tick;
        reset8 = 1'b0; reset128 = 1'b0;
        tick;

        // Reset state
        chk("rst_done8", 256'(done8), 256'd0);
        chk("rst_busy8", 256'(busy8), 256'd0);
        chk("rst_r8", 256'(r8), 256'd0);
        chk("rst_err8", 256'(err8), 256'd0);
        chk("rst_done128", 256'(done128), 256'd0);
        chk("rst_busy128", 256'(busy128), 256'd0);

        // 1000 mod 7, busy across the run
        go8(16'd1000, 8'd7);
        chk("busy8_first", 256'(busy8), 256'd1);
        repeat (15) tick;
        chk("busy8_last", 256'(busy8), 256'd1);
        chk("done8_early", 256'(done8), 256'd0);
        wait8(1);

        // All ones mod 255, then back-to-back start from DONE
        go8(16'hFFFF, 8'hFF);
        wait8(16);
        go8(16'h00FE, 8'hFF);
        chk("done8_drop", 256'(done8), 256'd0);
        wait8(16);

        // Zero modulus reports at once, next start clears err
        go8(16'h1234, 8'd0);
        chk("err8_imm", 256'(err8), 256'd1);
        wait8(0);
        go8(16'd5, 8'd13);
        chk("err8_clr", 256'(err8), 256'd0);
        wait8(16);

        // Start during RUN is ignored
        go8(16'd500, 8'd9);
        repeat (5) tick;
        x8 = 16'd1; p8 = 8'd3; st8 = 1'b1;
        tick;
        st8 = 1'b0;
        x8 = 16'hAAAA; p8 = 8'd0;
        wait8(10);

        // Boundary values
        go8(16'd0, 8'd5);
        wait8(16);
        go8(16'hBEEF, 8'd1);
        wait8(16);

        // Reset mid-run abandons the operation
        go8(16'd777, 8'd11);
        repeat (7) tick;
        reset8 = 1'b1;
        tick;
        reset8 = 1'b0;
        q8.delete();
        chk("mrst_done8", 256'(done8), 256'd0);
        chk("mrst_busy8", 256'(busy8), 256'd0);
        chk("mrst_r8", 256'(r8), 256'd0);
        repeat (20) tick;
        chk("mrst_idle8", 256'(done8), 256'd0);
        go8(16'd12345, 8'd97);
        wait8(16);

        // Wide corner cases
        pv = rnd128() | 128'd1;
        pm1 = pv - 128'd1;
        xv = 256'(pm1) * 256'(pm1);
        go128(xv, pv);
        wait128(256);
        go128({256{1'b1}}, pv);
        wait128(256);
        go128({256{1'b1}}, {128{1'b1}});
        wait128(256);
        go128(rnd128() * 256'd3, 128'd1);
        wait128(256);
        go128({rnd128(), rnd128()}, 128'd0);
        wait128(0);

        // Random back-to-back wide reductions
        for (int i = 0; i < 150; i++) begin
            pv = rnd128();
            if (i % 4 == 1) pv = pv >> ($urandom_range(0, 120));
            if (pv == 128'd0) pv = 128'd1;
            xv = {rnd128(), rnd128()};
            if (i % 10 == 3) begin
                pm1 = pv - 128'd1;
                xv = 256'(pm1) * 256'(pm1);
            end
            go128(xv, pv);
            wait128(256);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
